vagas_debounce_scan: RTL and testbench

- Upstream stage of the LED-matrix multiplexer in the parking-spot management design.
- Takes 8 raw spot-occupancy switches, synchronises and debounces each one, and presents clean occupancy bits to the matrix.
- Generates the column-alternation scan signal that the matrix multiplexer uses as its clock/select.
- Derives occupancy statistics: spot count, full/empty flags, and one-cycle car-in/car-out event pulses.

---
 rtl/vagas_pkg.sv | 20 ++
 rtl/vagas_debounce_scan_if.sv | 24 ++
 rtl/debounce_bit.sv | 42 ++++
 rtl/vagas_debounce_scan.sv | 80 ++++++++
 tb/tb_vagas_debounce_scan.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/vagas_pkg.sv
// Shared constants, types and helpers for the parking-spot debounce/scan front end.
package vagas_pkg;

    localparam int unsigned N_VAGAS        = 8;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned DEB_CYCLES_DEF = 500000;
    localparam int unsigned SCAN_DIV_DEF   = 25000;

    typedef logic [N_VAGAS-1:0] vagas_t;

    function automatic logic [CNT_W-1:0] popcount8(input vagas_t v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_VAGAS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/vagas_debounce_scan_if.sv
// Switch inputs and occupancy/scan outputs between the debounce stage and the matrix.
interface vagas_debounce_scan_if;
    import vagas_pkg::*;

    vagas_t           ch_raw;
    vagas_t           vaga_q;
    logic             scan_sel;
    logic [CNT_W-1:0] n_ocup;
    logic             lotado;
    logic             vazio;
    logic             entrada;
    logic             saida;

    modport master (
        output ch_raw,
        input  vaga_q, scan_sel, n_ocup, lotado, vazio, entrada, saida
    );

    modport slave (
        input  ch_raw,
        output vaga_q, scan_sel, n_ocup, lotado, vazio, entrada, saida
    );

endinterface

// File: rtl/debounce_bit.sv
// Two-flop synchroniser plus mismatch counter for a single switch.
module debounce_bit #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_q
);

    localparam int unsigned     DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_q;
    logic [DebW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_q    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            // Any return to the accepted level restarts the count.
            if (r_sync == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt == DebMax) begin
                r_q   <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DebW'(1);
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/vagas_debounce_scan.sv
// Debounces 8 spot switches, derives occupancy statistics and generates the matrix scan select.
module vagas_debounce_scan
    import vagas_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned SCAN_DIV   = SCAN_DIV_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    vagas_debounce_scan_if.slave bus
);

    localparam int unsigned    ScW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScW-1:0] ScMax = ScW'(SCAN_DIV - 1);

    vagas_t           w_vaga;
    logic [CNT_W-1:0] w_pop;

    for (genvar gi = 0; gi < N_VAGAS; gi++) begin : g_deb
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .i_raw (bus.ch_raw[gi]),
            .o_q   (w_vaga[gi])
        );
    end

    assign w_pop = popcount8(w_vaga);

    vagas_t           r_prev;
    logic [CNT_W-1:0] r_n_ocup;
    logic             r_lotado;
    logic             r_vazio;
    logic             r_entrada;
    logic             r_saida;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_n_ocup  <= '0;
            r_lotado  <= 1'b0;
            r_vazio   <= 1'b1;
            r_entrada <= 1'b0;
            r_saida   <= 1'b0;
        end else begin
            r_prev    <= w_vaga;
            r_n_ocup  <= w_pop;
            r_lotado  <= (w_pop == CNT_W'(N_VAGAS));
            r_vazio   <= (w_pop == '0);
            r_entrada <= |(w_vaga & ~r_prev);
            r_saida   <= |(~w_vaga & r_prev);
        end
    end

    logic [ScW-1:0] r_sc;
    logic           r_scan;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sc   <= '0;
            r_scan <= 1'b0;
        end else if (r_sc == ScMax) begin
            r_sc   <= '0;
            r_scan <= ~r_scan;
        end else begin
            r_sc <= r_sc + ScW'(1);
        end
    end

    assign bus.vaga_q   = w_vaga;
    assign bus.scan_sel = r_scan;
    assign bus.n_ocup   = r_n_ocup;
    assign bus.lotado   = r_lotado;
    assign bus.vazio    = r_vazio;
    assign bus.entrada  = r_entrada;
    assign bus.saida    = r_saida;

endmodule

// File: tb/tb_vagas_debounce_scan.sv
// Directed bench for vagas_debounce_scan with DEB_CYCLES = 4 and SCAN_DIV = 3.
module tb_vagas_debounce_scan;

    typedef struct packed {
        logic [7:0] raw;
        logic [7:0] vaga;
        logic [3:0] n;
        logic       lot;
        logic       vaz;
        logic       ent;
        logic       sai;
    } vec_t;

    localparam int NVEC = 22;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    vagas_debounce_scan_if bus ();

    vagas_debounce_scan #(
        .DEB_CYCLES (4),
        .SCAN_DIV   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] raw, input logic [7:0] vaga, input logic [3:0] n,
                                input logic lot, input logic vaz, input logic ent, input logic sai);
        vec_t v;
        v.raw  = raw;
        v.vaga = vaga;
        v.n    = n;
        v.lot  = lot;
        v.vaz  = vaz;
        v.ent  = ent;
        v.sai  = sai;
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ".vaga_q"}, 32'(bus.vaga_q), 32'h00);
        check({tag, ".n_ocup"}, 32'(bus.n_ocup), 32'd0);
        check({tag, ".lotado"}, 32'(bus.lotado), 32'd0);
        check({tag, ".vazio"}, 32'(bus.vazio), 32'd1);
        check({tag, ".entrada"}, 32'(bus.entrada), 32'd0);
        check({tag, ".saida"}, 32'(bus.saida), 32'd0);
        check({tag, ".scan_sel"}, 32'(bus.scan_sel), 32'd0);
    endtask

    initial begin
        int sai_cnt;
        checks = 0;
        errors = 0;

        // Step 2 rows: bit 2 rises; row k is observed after the (k+1)th edge.
        for (int k = 0; k < 5; k++) vecs[k] = mk(8'h04, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[5] = mk(8'h04, 8'h04, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6] = mk(8'h04, 8'h04, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[7] = mk(8'h04, 8'h04, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Step 3 rows: bit 5 bounces in 2-cycle bursts and must never be accepted.
        for (int j = 0; j < 14; j++) begin
            vecs[8 + j] = mk((j < 8 && ((j / 2) % 2 == 0)) ? 8'h24 : 8'h04,
                             8'h04, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 1. Reset, idle, scan cadence
        rst_n      = 1'b0;
        bus.ch_raw = 8'h00;
        tick();
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("scan_sel[%0d]", k), 32'(bus.scan_sel), 32'((k / 3) % 2));
        end
        check("idle.vaga_q", 32'(bus.vaga_q), 32'h00);
        check("idle.n_ocup", 32'(bus.n_ocup), 32'd0);
        check("idle.vazio", 32'(bus.vazio), 32'd1);
        check("idle.lotado", 32'(bus.lotado), 32'd0);

        // 2 + 3. Table-driven
        for (int i = 0; i < NVEC; i++) begin
            bus.ch_raw = vecs[i].raw;
            tick();
            check($sformatf("vec[%0d]", i),
                  32'({bus.vaga_q, bus.n_ocup, bus.lotado, bus.vazio, bus.entrada, bus.saida}),
                  32'({vecs[i].vaga, vecs[i].n, vecs[i].lot, vecs[i].vaz, vecs[i].ent,
                       vecs[i].sai}));
        end

        // 4. All spots full, then bit 7 drops
        bus.ch_raw = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) check("full.vaga_pre", 32'(bus.vaga_q), 32'h04);
            if (k == 6) check("full.vaga_q", 32'(bus.vaga_q), 32'hFF);
            if (k == 7) begin
                check("full.n_ocup", 32'(bus.n_ocup), 32'd8);
                check("full.lotado", 32'(bus.lotado), 32'd1);
                check("full.entrada", 32'(bus.entrada), 32'd1);
            end
            if (k == 8) check("full.entrada_end", 32'(bus.entrada), 32'd0);
        end
        bus.ch_raw = 8'h7F;
        sai_cnt    = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.saida) sai_cnt++;
            if (k == 6) check("drop7.vaga_q", 32'(bus.vaga_q), 32'h7F);
            if (k == 7) begin
                check("drop7.saida", 32'(bus.saida), 32'd1);
                check("drop7.n_ocup", 32'(bus.n_ocup), 32'd7);
                check("drop7.lotado", 32'(bus.lotado), 32'd0);
                check("drop7.entrada", 32'(bus.entrada), 32'd0);
            end
        end
        check("drop7.saida_pulses", 32'(sai_cnt), 32'd1);

        // 5. Simultaneous rise and fall
        bus.ch_raw = 8'h01;
        for (int k = 0; k < 10; k++) tick();
        check("swap.pre_vaga", 32'(bus.vaga_q), 32'h01);
        check("swap.pre_n", 32'(bus.n_ocup), 32'd1);
        bus.ch_raw = 8'h02;
        for (int k = 0; k < 5; k++) tick();
        check("swap.vaga_hold", 32'(bus.vaga_q), 32'h01);
        tick();
        check("swap.vaga_q", 32'(bus.vaga_q), 32'h02);
        tick();
        check("swap.entrada", 32'(bus.entrada), 32'd1);
        check("swap.saida", 32'(bus.saida), 32'd1);
        check("swap.n_ocup", 32'(bus.n_ocup), 32'd1);

        // 6. Reset while bit 3 is two counts into a pending rise
        bus.ch_raw = 8'h08;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("midreset");
        for (int k = 0; k < 5; k++) tick();
        check("midreset.vaga_hold", 32'(bus.vaga_q), 32'h00);
        tick();
        check("midreset.vaga_q", 32'(bus.vaga_q), 32'h08);
        tick();
        check("midreset.entrada", 32'(bus.entrada), 32'd1);
        check("midreset.n_ocup", 32'(bus.n_ocup), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
